pcm_rx_packer: RTL and testbench
================================

PCM_RX_PACKER -- requirements
Module: pcm_rx_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit output words buffered (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  system clock.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_en_i  input  1  block enable; low flushes the datapath.
REQ-005 SHALL have port cfg_pack_i  input  1  1 = two samples per word, 0 = one sample per word.
REQ-006 SHALL have port cfg_sign_ext_i  input  1  unpacked mode: 1 = sign-extend, 0 = zero-extend.
REQ-007 SHALL have port cfg_clr_ovf_i  input  1  single-cycle pulse that clears the sticky overflow flag.
REQ-008 SHALL have port pcm_data_i  input  16  PCM sample from the decimation filter.
REQ-009 SHALL have port pcm_valid_i  input  1  pcm_data_i valid this cycle.
REQ-010 SHALL have port pcm_ready_o  output  1  sample accepted.
REQ-011 SHALL have port data_o  output  32  word to the uDMA RX channel.
REQ-012 SHALL have port data_size_o  output  2  transfer size: 2'b01 = halfword, 2'b10 = word.
REQ-013 SHALL have port data_valid_o  output  1  data_o valid.
REQ-014 SHALL have port data_ready_i  input  1  uDMA accepts data_o.
REQ-015 SHALL have port ovf_o  output  1  sticky overflow, set when a word was dropped.
REQ-016 SHALL have port fifo_level_o  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Function
REQ-017 SHALL drive pcm_ready_o = cfg_en_i (the upstream filter does not stall); back-pressure is absorbed by the FIFO or by dropping.
REQ-018 SHALL latch the pack mode into r_pack on the rising edge of cfg_en_i; cfg_pack_i changes while enabled SHALL be ignored.
REQ-019 Packed mode: the first accepted sample SHALL be held in a half register (r_half_vld = 1); the second SHALL push {sample2, sample1} (first sample in bits [15:0]), clear r_half_vld, and set size 2'b10.
REQ-020 Unpacked mode: each accepted sample SHALL push one word, sign- or zero-extended per cfg_sign_ext_i, with size 2'b01.
REQ-021 A push SHALL be visible at data_valid_o on the cycle after the completing sample (1-cycle latency into an empty FIFO).
REQ-022 A word SHALL transfer when data_valid_o && data_ready_i; data_o and data_size_o SHALL hold stable while data_valid_o is high and data_ready_i is low.
REQ-023 Push when full with no pop in the same cycle: the word SHALL be dropped, ovf_o set, FIFO contents unchanged, and r_half_vld cleared.
REQ-024 Push and pop in the same cycle while full SHALL both succeed, with the level unchanged and no overflow.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH with an extra MSB for full/empty detection.
REQ-026 ovf_o SHALL stay set until cfg_clr_ovf_i; a clear and a new overflow in the same cycle SHALL leave ovf_o = 1.
REQ-027 With cfg_en_i low: the FIFO SHALL be flushed synchronously, r_half_vld cleared, data_valid_o = 0 on the next cycle, and ovf_o retained.
REQ-028 Deasserting cfg_en_i with a held half sample SHALL discard that sample; no partial word is emitted.

Reset
REQ-029 Asynchronous reset SHALL set data_valid_o = 0, data_o = 0, data_size_o = 2'b10, ovf_o = 0, fifo_level_o = 0, pcm_ready_o = 0 (follows cfg_en_i), r_half_vld = 0, r_pack = 0, pointers = 0.
REQ-030 Reset asserted mid-transfer SHALL drop all buffered data with no spurious valid after release.

Structure
REQ-031 Shared package pcm_rx_pkg SHALL hold the size encodings (SIZE_HALF = 2'b01, SIZE_WORD = 2'b10) and the 34-bit FIFO entry typedef {size, data}.
REQ-032 The FIFO SHALL be a sub-module pcm_rx_fifo (synchronous, registered output, flush input, level output).

Verification
REQ-033 Packed, ready = 1: samples 0x1111, 0x2222 -> one word 0x22221111, size 2'b10, valid 1 cycle after the second sample.
REQ-034 Unpacked, sign_ext = 1: sample 0x8001 -> 0xFFFF8001 size 2'b01; sign_ext = 0 -> 0x00008001.
REQ-035 Packed, ready = 0, 10 samples, FIFO_DEPTH = 4 -> level 4, ovf_o = 1, first 4 words drained in order once ready = 1.
REQ-036 Full FIFO with simultaneous push and pop -> level stays 4, ovf_o stays 0, order preserved.
REQ-037 Packed, one sample, then cfg_en_i low for 1 cycle, then re-enable and samples 0xA, 0xB -> word 0x000B000A; first sample discarded.
REQ-038 Reset asserted with 3 words buffered -> data_valid_o = 0 immediately, level 0, ovf_o = 0.

Source files
------------

// File: rtl/pcm_rx_pkg.sv
// Shared definitions for the PCM RX packer: transfer size encodings and FIFO entry layout.
package pcm_rx_pkg;

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pcm_rx_fifo.sv
// Synchronous FIFO of packed {size, data} entries with flush, level and drop reporting.
// Storage is register-based; the head entry is presented directly from the registers.
module pcm_rx_fifo
    import pcm_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  fifo_entry_t               wdata_i,
    input  logic                      pop_i,
    output fifo_entry_t               rdata_o,
    output logic                      empty_o,
    output logic                      drop_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level_o = wr_ptr - rd_ptr;
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    assign rdata_o = mem[rd_ptr[AW-1:0]];

    // Pointer update: flush returns to empty, otherwise advance on accepted push/pop
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; reset value gives data 0 / word size at the head after reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '{size: SIZE_WORD, data: '0};
            end
        end else if (do_push && !flush_i) begin
            mem[wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pcm_rx_packer.sv
// PCM RX packer: collects 16-bit PCM samples into 32-bit uDMA words (packed or
// sign/zero-extended), buffers them in a small FIFO and flags dropped words.
module pcm_rx_packer
    import pcm_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           cfg_en_i,
    input  logic                           cfg_pack_i,
    input  logic                           cfg_sign_ext_i,
    input  logic                           cfg_clr_ovf_i,
    input  logic [15:0]                    pcm_data_i,
    input  logic                           pcm_valid_i,
    output logic                           pcm_ready_o,
    output logic [31:0]                    data_o,
    output logic [1:0]                     data_size_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic                           ovf_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

    logic        r_en_d;
    logic        r_pack;
    logic        r_half_vld;
    logic [15:0] r_half;
    logic        r_ovf;

    logic        en_rise;
    logic        pack_eff;
    logic        accept;
    logic        push;
    logic        drop;
    logic        fifo_empty;
    logic [31:0] unpacked_word;
    fifo_entry_t wentry;
    fifo_entry_t rentry;

    assign pcm_ready_o = cfg_en_i;
    assign en_rise     = cfg_en_i && !r_en_d;
    // A sample may arrive on the enabling cycle itself, before r_pack has been
    // loaded, so that cycle uses the live mode input.
    assign pack_eff    = en_rise ? cfg_pack_i : r_pack;
    assign accept      = cfg_en_i && pcm_valid_i;

    // Word formation and push request for the sample presented this cycle
    always_comb begin
        unpacked_word = {{16{cfg_sign_ext_i & pcm_data_i[15]}}, pcm_data_i};
        push          = accept && (!pack_eff || r_half_vld);
        if (pack_eff) begin
            wentry = '{size: SIZE_WORD, data: {pcm_data_i, r_half}};
        end else begin
            wentry = '{size: SIZE_HALF, data: unpacked_word};
        end
    end

    // Enable edge detection and pack-mode latch on the rising edge of the enable
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en_d <= 1'b0;
            r_pack <= 1'b0;
        end else begin
            r_en_d <= cfg_en_i;
            if (en_rise) r_pack <= cfg_pack_i;
        end
    end

    // Half-word holding register for packed mode; discarded when disabled
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_half_vld <= 1'b0;
            r_half     <= '0;
        end else if (!cfg_en_i) begin
            r_half_vld <= 1'b0;
        end else if (accept && pack_eff) begin
            if (r_half_vld) begin
                r_half_vld <= 1'b0;
            end else begin
                r_half_vld <= 1'b1;
                r_half     <= pcm_data_i;
            end
        end
    end

    // Sticky overflow: a new drop wins over a simultaneous clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ovf <= 1'b0;
        end else if (drop) begin
            r_ovf <= 1'b1;
        end else if (cfg_clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    pcm_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (!cfg_en_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (data_ready_i),
        .rdata_o (rentry),
        .empty_o (fifo_empty),
        .drop_o  (drop),
        .level_o (fifo_level_o)
    );

    assign data_o       = rentry.data;
    assign data_size_o  = rentry.size;
    assign data_valid_o = !fifo_empty;
    assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_pcm_rx_packer.sv
// Self-checking bench for pcm_rx_packer: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_pcm_rx_packer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0;
    logic        pack = 1'b0;
    logic        sext = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] pdata = '0;
    logic        pvalid = 1'b0;
    logic        dready = 1'b0;
    logic        pcm_ready;
    logic [31:0] data_o;
    logic [1:0]  data_size;
    logic        data_valid;
    logic        ovf;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    pcm_rx_packer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cfg_en_i       (en),
        .cfg_pack_i     (pack),
        .cfg_sign_ext_i (sext),
        .cfg_clr_ovf_i  (clr),
        .pcm_data_i     (pdata),
        .pcm_valid_i    (pvalid),
        .pcm_ready_o    (pcm_ready),
        .data_o         (data_o),
        .data_size_o    (data_size),
        .data_valid_o   (data_valid),
        .data_ready_i   (dready),
        .ovf_o          (ovf),
        .fifo_level_o   (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of {size, data} words plus the pending half sample
    logic [33:0] mq[$];
    bit          m_half_vld;
    logic [15:0] m_half;
    bit          m_pack;
    bit          m_ovf;
    bit          m_en_prev;

    task automatic model_reset();
        mq.delete();
        m_half_vld = 0;
        m_half     = '0;
        m_pack     = 0;
        m_ovf      = 0;
        m_en_prev  = 0;
    endtask

    task automatic model_step();
        logic [33:0] w;
        bit          have_w;
        bit          popping;
        have_w  = 0;
        w       = '0;
        popping = (mq.size() != 0) && dready;
        if (clr) m_ovf = 0;
        if (!en) begin
            mq.delete();
            m_half_vld = 0;
        end else begin
            if (!m_en_prev) m_pack = pack;
            if (pvalid) begin
                if (m_pack) begin
                    if (m_half_vld) begin
                        w = {2'b10, pdata, m_half};
                        have_w = 1;
                        m_half_vld = 0;
                    end else begin
                        m_half = pdata;
                        m_half_vld = 1;
                    end
                end else begin
                    w = {2'b01, (sext ? {{16{pdata[15]}}, pdata} : {16'h0000, pdata})};
                    have_w = 1;
                end
            end
            if (popping) void'(mq.pop_front());
            if (have_w) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else m_ovf = 1;
            end
        end
        m_en_prev = en;
    endtask

    task automatic model_check();
        chk("rnd_valid", 32'(data_valid), 32'(mq.size() != 0));
        chk("rnd_level", 32'(level), 32'(mq.size()));
        chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("rnd_data", data_o, mq[0][31:0]);
            chk("rnd_size", 32'(data_size), 32'(mq[0][33:32]));
        end
    endtask

    typedef struct {
        logic        pack;
        logic        sext;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [31:0] exp_data;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] lo;
        logic [15:0] hi;
        int          rdy_pct;

        vecs[0] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 32'h2222_1111, 2'b10};
        vecs[1] = '{1'b0, 1'b1, 16'h8001, 16'h0000, 32'hFFFF_8001, 2'b01};
        vecs[2] = '{1'b0, 1'b0, 16'h8001, 16'h0000, 32'h0000_8001, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 32'h0000_7FFF, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 16'hABCD, 16'h8001, 32'h8001_ABCD, 2'b10};

        // Reset values
        #2 rstn = 1'b0;
        #2;
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_size", 32'(data_size), 32'd2);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(pcm_ready), 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Vector table: one word per entry, ready held high
        foreach (vecs[i]) begin
            en = 1'b0; pvalid = 1'b0; dready = 1'b1;
            tick();
            en = 1'b1; pack = vecs[i].pack; sext = vecs[i].sext;
            pvalid = 1'b1; pdata = vecs[i].s1;
            #1 chk("vec_pcm_ready", 32'(pcm_ready), 32'd1);
            tick();
            if (vecs[i].pack) begin
                chk("vec_half_no_valid", 32'(data_valid), 32'd0);
                pdata = vecs[i].s2;
                tick();
            end
            chk("vec_valid", 32'(data_valid), 32'd1);
            chk("vec_data", data_o, vecs[i].exp_data);
            chk("vec_size", 32'(data_size), 32'(vecs[i].exp_size));
            pvalid = 1'b0;
            tick();
            chk("vec_popped", 32'(data_valid), 32'd0);
        end

        // Mode change while enabled is ignored
        en = 1'b0; tick();
        en = 1'b1; pack = 1'b1; pvalid = 1'b1; pdata = 16'h1234; tick();
        pack = 1'b0; pdata = 16'h5678; tick();
        chk("latch_data", data_o, 32'h5678_1234);
        chk("latch_size", 32'(data_size), 32'd2);
        pvalid = 1'b0; tick();

        // Overflow with ready low, then ordered drain
        en = 1'b0; tick();
        en = 1'b1; pack = 1'b1; dready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pvalid = 1'b1; pdata = 16'h0100 + 16'(i);
            tick();
        end
        pvalid = 1'b0;
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        dready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lo = 16'h0100 + 16'(2 * k);
            hi = lo + 16'd1;
            chk("drain_valid", 32'(data_valid), 32'd1);
            chk("drain_data", data_o, {hi, lo});
            tick();
        end
        chk("drain_empty", 32'(data_valid), 32'd0);
        en = 1'b0; tick();
        chk("dis_keeps_ovf", 32'(ovf), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Full FIFO with simultaneous push and pop
        en = 1'b1; pack = 1'b0; sext = 1'b0; dready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pvalid = 1'b1; pdata = 16'h0010 + 16'(i);
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        pdata = 16'h0014; dready = 1'b1;
        tick();
        pvalid = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("pp_data", data_o, 32'h0000_0011 + 32'(k));
            tick();
        end
        chk("pp_empty", 32'(data_valid), 32'd0);

        // Clear and new overflow in the same cycle
        dready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pvalid = 1'b1; pdata = 16'h0020 + 16'(i);
            tick();
        end
        pdata = 16'h0024; clr = 1'b1;
        tick();
        clr = 1'b0; pvalid = 1'b0;
        chk("clr_vs_ovf", 32'(ovf), 32'd1);
        en = 1'b0; tick();
        chk("flush_valid", 32'(data_valid), 32'd0);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ovf", 32'(ovf), 32'd1);

        // Held half sample discarded by a one-cycle disable
        en = 1'b1; pack = 1'b1; pvalid = 1'b1; pdata = 16'h5555; tick();
        en = 1'b0; pvalid = 1'b0; tick();
        chk("discard_valid", 32'(data_valid), 32'd0);
        en = 1'b1; pvalid = 1'b1; pdata = 16'h000A; tick();
        chk("discard_half", 32'(data_valid), 32'd0);
        pdata = 16'h000B; tick();
        pvalid = 1'b0;
        chk("discard_data", data_o, 32'h000B_000A);
        chk("discard_wvalid", 32'(data_valid), 32'd1);
        dready = 1'b1; tick();
        chk("discard_pop", 32'(data_valid), 32'd0);

        // Reset with three words buffered
        en = 1'b0; tick();
        en = 1'b1; pack = 1'b0; dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pvalid = 1'b1; pdata = 16'h0300 + 16'(i);
            tick();
        end
        pvalid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_valid", 32'(data_valid), 32'd0);
        tick();
        chk("post_rst_level", 32'(level), 32'd0);

        // Randomized run against the reference model
        en = 1'b0; pvalid = 1'b0; dready = 1'b0; clr = 1'b0;
        #2 rstn = 1'b0;
        tick();
        rstn = 1'b1;
        model_reset();
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) rdy_pct = (c / 150) % 3 == 0 ? 10 : ((c / 150) % 3 == 1 ? 50 : 90);
            en     = (c % 150 != 149);
            pack   = 1'($urandom_range(0, 1));
            sext   = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 39) == 0);
            pvalid = ($urandom_range(0, 3) != 0);
            pdata  = 16'($urandom);
            dready = (int'($urandom_range(0, 99)) < rdy_pct);
            model_check();
            model_step();
            tick();
        end
        model_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
